// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch-mispredict flush and
// instruction-fetch wait handling for a classic five-stage pipeline.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall/flush
// event counters (perf_stall_cnt, perf_flush_cnt).
// Flush timing: the bubble counter is loaded with FLUSH_CYCLES-1 on a
// mispredict and decremented (saturating at 0) on every FLUSH cycle; FLUSH is
// left once the decremented value reaches 0, so FLUSH lasts at least one cycle.
// Hazard outputs depend combinationally on the current inputs and are forced
// low while reset is high.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch,
  input  logic       ex_zero,
  input  logic       if_take,
  input  logic       imem_ready,
  output logic       ex_mem_stall,
  output logic       ex_flush,
  output logic       id_ex_bubble,
  output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_IWAIT   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic mispredict_c;
  logic load_use_c;
  logic stall_c;
  logic flush_c;
  logic bubble_c;

  // Hazard detection terms from the current EX/ID contents
  always_comb begin
    mispredict_c = ex_branch & (ex_zero != if_take);
    load_use_c   = ex_mem_read & (ex_rd != 5'd0) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) |
                    (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  // Next-state, bubble counter and hazard output decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    case (state)
      ST_RUN: begin
        if (mispredict_c) begin
          flush_c   = 1'b1;
          cnt_nxt   = FLUSH_LOAD;
          state_nxt = ST_FLUSH;
        end else if (load_use_c) begin
          stall_c   = 1'b1;
          bubble_c  = 1'b1;
          state_nxt = ST_LDSTALL;
        end else if (!imem_ready) begin
          stall_c   = 1'b1;
          bubble_c  = 1'b1;
          state_nxt = ST_IWAIT;
        end
      end
      ST_LDSTALL: begin
        state_nxt = ST_RUN;
      end
      ST_FLUSH: begin
        bubble_c = 1'b1;
        cnt_nxt  = (cnt == '0) ? '0 : cnt - CNT_W'(1);
        if (cnt_nxt == '0) begin
          state_nxt = ST_RUN;
        end
      end
      ST_IWAIT: begin
        if (mispredict_c) begin
          flush_c   = 1'b1;
          cnt_nxt   = FLUSH_LOAD;
          state_nxt = ST_FLUSH;
        end else if (imem_ready) begin
          state_nxt = ST_RUN;
        end else begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and bubble counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs held low for the whole reset window
  always_comb begin
    ex_mem_stall = stall_c & ~reset;
    ex_flush     = flush_c & ~reset;
    id_ex_bubble = bubble_c & ~reset;
    ctrl_state   = state;
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters for stall cycles and flush pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (ex_mem_stall && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (ex_flush && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
